alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command-side front end for the team's 3-bit-select ALU: accepts R-type arithmetic commands over a valid/ready handshake and decodes the 6-bit funct into the ALU select. It drives registered operands and select into the combinational ALU, captures the ALU result one cycle later, and returns it over a valid/ready response channel. It sits between the register-read stage and the ALU, and replaces hand-driven select lines in the datapath.

## Interface
- N, 32, operand/result width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  issuer can accept a command
- cmd_funct  input  6  R-type funct code
- cmd_a  input  N  operand A (signed)
- cmd_b  input  N  operand B (signed)
- alu_sel  output  3  select to ALU
- alu_a  output  N  ALU operand A
- alu_b  output  N  ALU operand B
- alu_result  input  N  combinational ALU output
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  N  captured result
- rsp_err  output  1  illegal funct
- rsp_zero, rsp_neg, rsp_ovf  output  1 each  result flags (see Configuration)
- op_count  output  16  completed-response counter

## Operation
- ALU select encoding: 000 pass A, 001 NOT A, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 signed SLT.
- Funct decode: 0x20→010, 0x22→100, 0x24→110, 0x27→011, 0x2A→111, 0x25 (custom NAND)→101, 0x26 (custom NOT)→001, 0x00 (MOV)→000. Any other funct is illegal.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch funct/a/b. Legal funct → ISSUE. Illegal funct → RESP with rsp_err=1, rsp_data=0.
  - ISSUE: alu_sel/alu_a/alu_b are driven from registers; → CAPTURE.
  - CAPTURE: register alu_result into rsp_data, rsp_err=0; → RESP.
  - RESP: rsp_valid=1. Hold rsp_data/rsp_err/flags stable until rsp_ready. On rsp_valid && rsp_ready, increment op_count and → IDLE.
- alu_sel/alu_a/alu_b hold their last values outside ISSUE (no toggling).
- op_count increments by 1 per completed response, illegal ones included, and wraps 0xFFFF→0x0000.
- No new command is accepted in RESP, even when rsp_ready is high in the same cycle. Throughput is at most one command per 4 cycles.

## Timing
- Command accepted at edge k. Legal: rsp_valid=1 after edge k+3 (ISSUE k+1, CAPTURE k+2, RESP k+3). Illegal: rsp_valid=1 after edge k+1.
- cmd_ready is 0 from edge k+1 until the edge that completes the response.
- Reset values: cmd_ready=1 (state IDLE), rsp_valid=0, rsp_data=0, rsp_err=0, all flags 0, alu_sel=000, alu_a=0, alu_b=0, op_count=0.
- Reset asserted mid-transaction: the in-flight command is discarded, no response is produced, and op_count is not incremented. rst has priority over every handshake in the same cycle.
- A rsp_ready pulse while rsp_valid=0 is ignored.

## Configuration
- ALU_CMD_ISSUER_FLAGS_EN defined: flags are registered in CAPTURE.
  - rsp_zero = (result==0).
  - rsp_neg = result[N-1].
  - rsp_ovf = signed overflow for ADD/SUB only, computed from latched operands; 0 for all other ops.
  - On illegal funct: rsp_zero=1, others 0.
- Not defined: ports remain and are tied to 0; no flag logic is synthesized.

## Structure
- Shared package alu_pkg: 3-bit select localparams (ALU_PASS…ALU_SLT), funct constants, FSM state encoding.
- One sub-module: alu_funct_decode, a combinational funct→{sel, legal} decoder reusable by the control unit.
- The ALU itself is instantiated outside this block.

## Test plan
- Reset, then ADD funct 0x20, a=5, b=7, alu model attached → rsp_valid 3 cycles after accept, rsp_data=12, rsp_err=0, op_count=1.
- SLT 0x2A, a=-1 (0xFFFFFFFF), b=1 → rsp_data=1. SUB 0x22, a=3, b=3 → rsp_data=0, rsp_zero=1 (flags build).
- ADD a=0x7FFFFFFF, b=1 → rsp_data=0x80000000, rsp_ovf=1, rsp_neg=1 with flags; all flags 0 without macro.
- Illegal funct 0x3F → rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, alu_sel unchanged.
- Hold rsp_ready=0 for 5 cycles with cmd_valid asserted → cmd_ready stays 0, rsp_data stable; release → response consumed, next command accepted the following cycle.
- Assert rst during CAPTURE → rsp_valid never rises, op_count unchanged, cmd_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes, R-type funct codes and issuer FSM states.
package alu_pkg;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_NOT  = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_NOR  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic [2:0] ALU_NAND = 3'b101;
   localparam logic [2:0] ALU_AND  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [5:0] F_MOV  = 6'h00;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_NAND = 6'h25;
   localparam logic [5:0] F_NOT  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct to ALU select decoder with legality flag.
module alu_funct_decode
   import alu_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] sel_o,
   output logic       legal_o
);

   always_comb begin
      sel_o   = ALU_PASS;
      legal_o = 1'b1;
      case (funct_i)
         F_ADD:   sel_o = ALU_ADD;
         F_SUB:   sel_o = ALU_SUB;
         F_AND:   sel_o = ALU_AND;
         F_NOR:   sel_o = ALU_NOR;
         F_SLT:   sel_o = ALU_SLT;
         F_NAND:  sel_o = ALU_NAND;
         F_NOT:   sel_o = ALU_NOT;
         F_MOV:   sel_o = ALU_PASS;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Valid/ready front end: decodes funct, drives the ALU, returns its result.
// Optional result flags are built when ALU_CMD_ISSUER_FLAGS_EN is defined.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [5:0]   cmd_funct,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   output logic [2:0]   alu_sel,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data,
   output logic         rsp_err,
   output logic         rsp_zero,
   output logic         rsp_neg,
   output logic         rsp_ovf,
   output logic [15:0]  op_count
);

   state_e       state_q;
   logic [2:0]   sel_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic [N-1:0] data_q;
   logic         err_q;
   logic [15:0]  cnt_q;
   logic [15:0]  cnt_d;
   logic [2:0]   dec_sel;
   logic         dec_legal;

   alu_funct_decode u_dec (
      .funct_i (cmd_funct),
      .sel_o   (dec_sel),
      .legal_o (dec_legal)
   );

   assign cnt_d = cnt_q + 16'd1;

   // ALU drive registers only load on a legal accept, so they hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= ALU_PASS;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (dec_legal) begin
                     sel_q   <= dec_sel;
                     a_q     <= cmd_a;
                     b_q     <= cmd_b;
                     state_q <= S_ISSUE;
                  end else begin
                     data_q  <= '0;
                     err_q   <= 1'b1;
                     state_q <= S_RESP;
                  end
               end
            end
            S_ISSUE: state_q <= S_CAPTURE;
            S_CAPTURE: begin
               data_q  <= alu_result;
               err_q   <= 1'b0;
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  cnt_q   <= cnt_d;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign alu_sel   = sel_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;
   assign op_count  = cnt_q;

`ifdef ALU_CMD_ISSUER_FLAGS_EN
   logic zero_q;
   logic neg_q;
   logic ovf_q;
   logic ovf_d;
   logic sa;
   logic sb;
   logic sr;

   assign sa = a_q[N-1];
   assign sb = b_q[N-1];
   assign sr = alu_result[N-1];

   always_comb begin
      ovf_d = 1'b0;
      if (sel_q == ALU_ADD)
         ovf_d = (sa == sb) && (sr != sa);
      else if (sel_q == ALU_SUB)
         ovf_d = (sa != sb) && (sr != sa);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == S_IDLE && cmd_valid && !dec_legal) begin
         zero_q <= 1'b1;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == S_CAPTURE) begin
         zero_q <= (alu_result == '0);
         neg_q  <= sr;
         ovf_q  <= ovf_d;
      end
   end

   assign rsp_zero = zero_q;
   assign rsp_neg  = neg_q;
   assign rsp_ovf  = ovf_q;
`else
   assign rsp_zero = 1'b0;
   assign rsp_neg  = 1'b0;
   assign rsp_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU attached.
module tb_alu_cmd_issuer;

`ifdef ALU_CMD_ISSUER_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_funct;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic [2:0]  alu_sel;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_zero;
   logic        rsp_neg;
   logic        rsp_ovf;
   logic [15:0] op_count;

   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] exp_cnt = '0;
   logic [2:0]  exp_sel = '0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(.N(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_funct  (cmd_funct),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_sel    (alu_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .rsp_zero   (rsp_zero),
      .rsp_neg    (rsp_neg),
      .rsp_ovf    (rsp_ovf),
      .op_count   (op_count)
   );

   // External ALU, as it sits in the datapath
   always_comb begin
      alu_result = '0;
      case (alu_sel)
         3'd0: alu_result = alu_a;
         3'd1: alu_result = ~alu_a;
         3'd2: alu_result = alu_a + alu_b;
         3'd3: alu_result = ~(alu_a | alu_b);
         3'd4: alu_result = alu_a - alu_b;
         3'd5: alu_result = ~(alu_a & alu_b);
         3'd6: alu_result = alu_a & alu_b;
         3'd7: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [2:0] sel_of(input logic [5:0] f);
      case (f)
         6'h20: return 3'b010;
         6'h22: return 3'b100;
         6'h24: return 3'b110;
         6'h27: return 3'b011;
         6'h2A: return 3'b111;
         6'h25: return 3'b101;
         6'h26: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Reference: result/error/flags straight from the funct semantics
   task automatic ref_model(input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] d,
                            output logic e, output logic [2:0] fl);
      longint sa, sb, s;
      logic   ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = 0;
      e  = 1'b0;
      d  = '0;
      case (f)
         6'h20: begin s = sa + sb; d = s[31:0]; end
         6'h22: begin s = sa - sb; d = s[31:0]; end
         6'h24: d = a & b;
         6'h27: d = ~(a | b);
         6'h2A: d = (sa < sb) ? 32'd1 : 32'd0;
         6'h25: d = ~(a & b);
         6'h26: d = ~a;
         6'h00: d = a;
         default: e = 1'b1;
      endcase
      ov = (f == 6'h20 || f == 6'h22) &&
           (s > 64'sd2147483647 || s < -64'sd2147483648);
      if (!FLAGS) fl = 3'b000;
      else if (e) fl = 3'b100;
      else fl = {d == 32'd0, d[31], ov};
   endtask

   task automatic run_cmd(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output int wait_cyc);
      logic [31:0] ed;
      logic        ee;
      logic [2:0]  ef;
      int          lat;
      ref_model(f, a, b, ed, ee, ef);
      cmd_funct = f;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      wait_cyc  = 0;
      while (!cmd_ready && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rsp_latency", lat, ee ? 32'd1 : 32'd3);
      check("rsp_data", rsp_data, ed);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
      check("rsp_flags", {29'd0, rsp_zero, rsp_neg, rsp_ovf}, {29'd0, ef});
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (!ee) exp_sel = sel_of(f);
      check("alu_sel", {29'd0, alu_sel}, {29'd0, exp_sel});
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         cmd_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_ready", {31'd0, cmd_ready}, 32'd0);
         check("hold_data", rsp_data, ed);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      exp_cnt   = exp_cnt + 16'd1;
      check("rsp_done", {31'd0, rsp_valid}, 32'd0);
      check("ready_back", {31'd0, cmd_ready}, 32'd1);
      check("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
   endtask

   typedef struct {
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      logic        e;
      int          hold;
   } vec_t;

   vec_t        vt[9];
   logic [5:0]  lf[8];
   logic [31:0] bnd[5];

   initial begin
      int          w;
      logic [5:0]  f;
      logic [31:0] a, b;

      vt[0] = '{6'h20, 32'd5, 32'd7, 32'd12, 1'b0, 0};
      vt[1] = '{6'h2A, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 0};
      vt[2] = '{6'h22, 32'd3, 32'd3, 32'd0, 1'b0, 0};
      vt[3] = '{6'h20, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 0};
      vt[4] = '{6'h3F, 32'd1, 32'd2, 32'd0, 1'b1, 0};
      vt[5] = '{6'h26, 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0, 1'b0, 0};
      vt[6] = '{6'h25, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0FFF0FF, 1'b0, 0};
      vt[7] = '{6'h00, 32'h12345678, 32'd9, 32'h12345678, 1'b0, 5};
      vt[8] = '{6'h27, 32'hF0F00000, 32'h000F0F00, 32'h0F00F0FF, 1'b0, 0};
      lf  = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h2A, 6'h25, 6'h26, 6'h00};
      bnd = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_funct = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_flags", {29'd0, rsp_zero, rsp_neg, rsp_ovf}, 32'd0);
      check("rst_alu", {alu_sel, 29'd0} | alu_a | alu_b, 32'd0);
      check("rst_op_count", {16'd0, op_count}, 32'd0);

      // Directed table; the table's own expected data cross-checks the model
      for (int i = 0; i < 9; i++) begin
         logic [31:0] md;
         logic        me;
         logic [2:0]  mf;
         ref_model(vt[i].f, vt[i].a, vt[i].b, md, me, mf);
         check("table_vs_model", {md[31:1], md[0] ^ me}, {vt[i].d[31:1], vt[i].d[0] ^ vt[i].e});
         run_cmd(vt[i].f, vt[i].a, vt[i].b, vt[i].hold, w);
         if (i == 8) check("accept_after_hold", w, 32'd0);
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) f = 6'($urandom_range(0, 63));
         else f = lf[$urandom_range(0, 7)];
         a = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 2) == 0) ? bnd[$urandom_range(0, 4)] : $urandom;
         run_cmd(f, a, b, $urandom_range(0, 2), w);
      end

      // Reset during CAPTURE discards the command
      cmd_funct = 6'h20;
      cmd_a     = 32'd10;
      cmd_b     = 32'd20;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt = '0;
      exp_sel = '0;
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("midrst_op_count", {16'd0, op_count}, 32'd0);
      check("midrst_alu_sel", {29'd0, alu_sel}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
         check("stray_ready_cnt", {16'd0, op_count}, 32'd0);
      end
      rsp_ready = 1'b0;
      run_cmd(6'h22, 32'd3, 32'd5, 1, w);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
